// File: rtl/pcpu_pkg.sv
// Shared types and constants for the pipelined CPU front end.
// Holds the PC/instruction widths, the NOP encoding and the fetch-queue entry layout.
package pcpu_pkg;

  localparam int PC_W     = 7;
  localparam int INSN_W   = 32;
  localparam int PQ_DEPTH = 4;
  localparam int PTR_W    = $clog2(PQ_DEPTH);

  typedef logic [PC_W-1:0]   pc_t;
  typedef logic [INSN_W-1:0] insn_t;

  localparam insn_t NOP_INSN = 32'h0;

  // One buffered fetch: the instruction word and the PC+1 that decode feeds to its branch adder.
  typedef struct packed {
    insn_t insn;
    pc_t   pcPlus1;
  } fetch_entry_t;

  function automatic pc_t pcNext(input pc_t pc);
    return pc + pc_t'(1);
  endfunction

endpackage

// File: rtl/pq_fifo.sv
// Synchronous FIFO for the prefetch queue: power-of-two storage, free-running
// pointers, a separate occupancy counter and a synchronous clear used on redirect.
module pq_fifo
  import pcpu_pkg::*;
#(
  parameter  int DEPTH = PQ_DEPTH,
  localparam int PtrW  = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  fetch_entry_t  pushEntry,
  input  logic          pop,
  output fetch_entry_t  headEntry,
  output logic          empty,
  output logic          full,
  output logic [PtrW:0] count
);

  fetch_entry_t    mem [DEPTH];
  logic [PtrW-1:0] rdPtr;
  logic [PtrW-1:0] wrPtr;
  logic            doPush;
  logic            doPop;

  assign empty     = (count == '0);
  assign full      = (count == (PtrW+1)'(DEPTH));
  assign doPush    = push && !full;
  assign doPop     = pop && !empty;
  assign headEntry = mem[rdPtr];

  // NOTE: storage has no reset; every read of it is qualified by the occupancy count.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushEntry;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PtrW'(1);
      if (doPop)  rdPtr <= rdPtr + PtrW'(1);
      count <= count + (PtrW+1)'(doPush) - (PtrW+1)'(doPop);
    end
  end

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues 1-cycle ROM reads and
// buffers returned words for decode behind a valid/ready handshake.
module if_prefetch_queue
  import pcpu_pkg::*;
#(
  parameter  int DEPTH = PQ_DEPTH,
  localparam int CntW  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              rom_en,
  output logic [PC_W-1:0]   rom_addr,
  input  logic [INSN_W-1:0] rom_data,
  output logic              insn_valid,
  input  logic              insn_ready,
  output logic [INSN_W-1:0] insn,
  output logic [PC_W-1:0]   insn_pc_plus1,
  output logic [CntW-1:0]   occupancy
);

  pc_t          fetchPc;
  pc_t          tagPc;
  logic         inflight;
  logic         drop;
  logic         issue;
  logic         push;
  logic         pop;
  logic         empty;
  logic         full;
  logic [CntW:0] pending;
  fetch_entry_t pushEntry;
  fetch_entry_t headEntry;

  // Credit counts the queued words plus the one in flight; a same-cycle pop is not credited.
  assign pending = {1'b0, occupancy} + (CntW+1)'(inflight);
  // Gated by rst_n so no read is requested while reset is being held.
  assign issue   = rst_n && !redirect_valid && (pending < (CntW+1)'(DEPTH));

  assign rom_en   = issue;
  assign rom_addr = fetchPc;

  assign push = inflight && !drop && !redirect_valid;
  assign pop  = insn_valid && insn_ready && !redirect_valid;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    pushEntry         = '0;
    pushEntry.insn    = rom_data;
    pushEntry.pcPlus1 = pcNext(tagPc);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetchPc  <= '0;
      tagPc    <= '0;
      inflight <= 1'b0;
      drop     <= 1'b0;
    end else begin
      inflight <= issue;
      // Kills a response that would land after a redirect that coincided with its issue.
      drop     <= redirect_valid && issue;
      if (issue) tagPc <= fetchPc;
      if (redirect_valid) fetchPc <= redirect_pc;
      else if (issue)     fetchPc <= pcNext(fetchPc);
    end
  end

  pq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (redirect_valid),
    .push      (push),
    .pushEntry (pushEntry),
    .pop       (pop),
    .headEntry (headEntry),
    .empty     (empty),
    .full      (full),
    .count     (occupancy)
  );

  assign insn_valid    = !empty;
  assign insn          = insn_valid ? headEntry.insn : NOP_INSN;
  assign insn_pc_plus1 = insn_valid ? headEntry.pcPlus1 : '0;

endmodule
